inst_fetch: RTL and testbench

- Fetch front end of the 9-bit CPU. It owns the 11-bit program counter and drives InstAddress into the instruction ROM.
- It captures the returned 9-bit word into an instruction register for the decoder. It applies taken branches from downstream and detects the halt word.
- It runs the Start/Ack program handshake with the testbench: load the start address, run, halt, acknowledge.

---
 rtl/inst_fetch.sv | 116 +++++++++++
 tb/tb_inst_fetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Fetch front end of the 9-bit CPU: owns the PC, registers the ROM word into IR,
// applies taken branches and runs the Start/Ack program handshake.
module inst_fetch #(
  parameter int unsigned       AW        = 11,
  parameter int unsigned       IW        = 9,
  parameter logic [IW-1:0]     HALT_WORD = 9'h1FF,
  parameter int unsigned       CW        = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] StartAddr,
  output logic [AW-1:0] InstAddress,
  input  logic [IW-1:0] InstOut,
  input  logic          Stall,
  input  logic          BranchTaken,
  input  logic          BranchRel,
  input  logic [AW-1:0] BranchTarget,
  output logic [IW-1:0] IR,
  output logic [AW-1:0] IRAddr,
  output logic          IRValid,
  output logic          Ack,
  output logic [CW-1:0] InstCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [IW-1:0] ir_q;
  logic [AW-1:0] ir_addr_q;
  logic          ir_valid_q;
  logic          ack_q;
  logic [CW-1:0] cnt_q;

  logic [AW-1:0] pc_seq_d;
  logic [AW-1:0] pc_br_d;
  logic [CW-1:0] cnt_inc_d;
  logic          halt;
  logic          branch;

  always_comb begin
    pc_seq_d  = pc_q + AW'(1);
    pc_br_d   = BranchRel ? (ir_addr_q + BranchTarget) : BranchTarget;
    cnt_inc_d = (cnt_q == '1) ? cnt_q : (cnt_q + CW'(1));
    halt      = ir_valid_q && (ir_q == HALT_WORD) && !Stall;
    branch    = ir_valid_q && BranchTaken;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_addr_q  <= '0;
      ir_valid_q <= 1'b0;
      ack_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ir_valid_q <= 1'b0;
          ack_q      <= 1'b0;
          if (Start) begin
            pc_q    <= StartAddr;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Halt wins over branch; a taken branch overrides Stall.
          if (halt) begin
            state_q    <= DONE;
            ir_valid_q <= 1'b0;
            ack_q      <= 1'b1;
            cnt_q      <= cnt_inc_d;
          end else if (branch) begin
            pc_q       <= pc_br_d;
            ir_valid_q <= 1'b0;
            cnt_q      <= cnt_inc_d;
          end else if (!Stall) begin
            ir_q       <= InstOut;
            ir_addr_q  <= pc_q;
            ir_valid_q <= 1'b1;
            pc_q       <= pc_seq_d;
            if (ir_valid_q) begin
              cnt_q <= cnt_inc_d;
            end
          end
        end
        DONE: begin
          ir_valid_q <= 1'b0;
          if (Start) begin
            ack_q   <= 1'b0;
            pc_q    <= StartAddr;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign InstAddress = pc_q;
  assign IR          = ir_q;
  assign IRAddr      = ir_addr_q;
  assign IRValid     = ir_valid_q;
  assign Ack         = ack_q;
  assign InstCount   = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch with a combinational ROM model.
module tb_inst_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [10:0] StartAddr;
  logic [10:0] InstAddress;
  logic [8:0]  InstOut;
  logic        Stall;
  logic        BranchTaken;
  logic        BranchRel;
  logic [10:0] BranchTarget;
  logic [8:0]  IR;
  logic [10:0] IRAddr;
  logic        IRValid;
  logic        Ack;
  logic [15:0] InstCount;

  logic [8:0] rom [2048];
  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  assign InstOut = rom[InstAddress];

  inst_fetch #(.AW(11), .IW(9), .HALT_WORD(9'h1FF), .CW(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .InstAddress(InstAddress), .InstOut(InstOut), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchRel(BranchRel), .BranchTarget(BranchTarget),
    .IR(IR), .IRAddr(IRAddr), .IRValid(IRValid), .Ack(Ack), .InstCount(InstCount)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  task automatic start_prog(input logic [10:0] addr);
    StartAddr = addr;
    Start     = 1'b1;
    tick();
    Start     = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #2;
    checks++; if (InstAddress !== 11'h000) begin errors++; $display("FAIL reset_pc: got %h want 000", InstAddress); end
    checks++; if (IRValid !== 1'b0) begin errors++; $display("FAIL reset_irvalid: got %b want 0", IRValid); end
    checks++; if (Ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", Ack); end
    checks++; if (InstCount !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", InstCount); end
    checks++; if (IR !== 9'h000 || IRAddr !== 11'h000) begin errors++; $display("FAIL reset_ir: got %h@%h want 000@000", IR, IRAddr); end
    tick();
    Reset = 1'b1;
    tick();
    checks++; if (InstAddress !== 11'h000 || IRValid !== 1'b0) begin errors++; $display("FAIL idle_hold: got pc %h v %b want 000 0", InstAddress, IRValid); end
  endtask

  task automatic test_program();
    do_reset();
    start_prog(11'h000);
    checks++; if (InstAddress !== 11'h000 || IRValid !== 1'b0) begin errors++; $display("FAIL prog_start: got pc %h v %b want 000 0", InstAddress, IRValid); end
    tick();
    checks++; if (IR !== 9'h001 || IRAddr !== 11'h000 || IRValid !== 1'b1) begin errors++; $display("FAIL prog_ir0: got %h@%h v%b want 001@000 v1", IR, IRAddr, IRValid); end
    tick();
    checks++; if (IR !== 9'h049 || IRAddr !== 11'h001) begin errors++; $display("FAIL prog_ir1: got %h@%h want 049@001", IR, IRAddr); end
    tick();
    checks++; if (IR !== 9'h1FF || IRAddr !== 11'h002 || Ack !== 1'b0) begin errors++; $display("FAIL prog_ir2: got %h@%h ack %b want 1ff@002 ack 0", IR, IRAddr, Ack); end
    checks++; if (InstCount !== 16'd2) begin errors++; $display("FAIL prog_cnt2: got %0d want 2", InstCount); end
    tick();
    checks++; if (Ack !== 1'b1 || InstCount !== 16'd3 || IRValid !== 1'b0) begin errors++; $display("FAIL prog_done: got ack %b cnt %0d v %b want 1 3 0", Ack, InstCount, IRValid); end
    tick();
    checks++; if (Ack !== 1'b1 || InstCount !== 16'd3 || InstAddress !== 11'h003) begin errors++; $display("FAIL done_hold: got ack %b cnt %0d pc %h want 1 3 003", Ack, InstCount, InstAddress); end
  endtask

  task automatic test_done_restart();
    start_prog(11'h020);
    checks++; if (Ack !== 1'b0 || InstCount !== 16'd0 || InstAddress !== 11'h020) begin errors++; $display("FAIL restart: got ack %b cnt %0d pc %h want 0 0 020", Ack, InstCount, InstAddress); end
    tick();
    checks++; if (IR !== 9'h020 || IRAddr !== 11'h020) begin errors++; $display("FAIL restart_ir: got %h@%h want 020@020", IR, IRAddr); end
  endtask

  task automatic test_abs_branch();
    do_reset();
    start_prog(11'h003);
    tick(); tick(); tick();
    checks++; if (IRAddr !== 11'h005 || IR !== 9'h005) begin errors++; $display("FAIL abs_pre: got %h@%h want 005@005", IR, IRAddr); end
    BranchTaken = 1'b1; BranchRel = 1'b0; BranchTarget = 11'h010;
    tick();
    BranchTaken = 1'b0;
    checks++; if (InstAddress !== 11'h010 || IRValid !== 1'b0) begin errors++; $display("FAIL abs_br: got pc %h v %b want 010 0", InstAddress, IRValid); end
    tick();
    checks++; if (IR !== 9'h010 || IRAddr !== 11'h010 || IRValid !== 1'b1) begin errors++; $display("FAIL abs_fetch: got %h@%h v%b want 010@010 v1", IR, IRAddr, IRValid); end
    checks++; if (InstCount !== 16'd3) begin errors++; $display("FAIL abs_cnt: got %0d want 3", InstCount); end
  endtask

  task automatic test_rel_branch();
    do_reset();
    start_prog(11'h003);
    tick(); tick();
    BranchTaken = 1'b1; BranchRel = 1'b1; BranchTarget = 11'h7FE;
    tick();
    BranchTaken = 1'b0;
    checks++; if (InstAddress !== 11'h002 || IRValid !== 1'b0) begin errors++; $display("FAIL rel_br: got pc %h v %b want 002 0", InstAddress, IRValid); end
  endtask

  task automatic test_rel_wrap();
    do_reset();
    start_prog(11'h7FF);
    tick();
    BranchTaken = 1'b1; BranchRel = 1'b1; BranchTarget = 11'h003;
    tick();
    BranchTaken = 1'b0;
    checks++; if (InstAddress !== 11'h002) begin errors++; $display("FAIL rel_wrap: got pc %h want 002", InstAddress); end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    start_prog(11'h7FF);
    checks++; if (InstAddress !== 11'h7FF) begin errors++; $display("FAIL wrap_first: got %h want 7ff", InstAddress); end
    tick();
    checks++; if (InstAddress !== 11'h000 || IR !== 9'h0FF || IRAddr !== 11'h7FF) begin errors++; $display("FAIL wrap_second: got pc %h ir %h@%h want 000 0ff@7ff", InstAddress, IR, IRAddr); end
  endtask

  task automatic test_branch_when_invalid();
    do_reset();
    start_prog(11'h030);
    BranchTaken = 1'b1; BranchRel = 1'b0; BranchTarget = 11'h300;
    StartAddr = 11'h500; Start = 1'b1;
    tick();
    BranchTaken = 1'b0; Start = 1'b0;
    checks++; if (InstAddress !== 11'h031 || IRAddr !== 11'h030 || IRValid !== 1'b1) begin errors++; $display("FAIL br_invalid: got pc %h ira %h v %b want 031 030 1", InstAddress, IRAddr, IRValid); end
  endtask

  task automatic test_stall();
    do_reset();
    start_prog(11'h040);
    tick(); tick();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (InstAddress !== 11'h042 || IR !== 9'h041 || IRAddr !== 11'h041 || InstCount !== 16'd1 || IRValid !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d: got pc %h ir %h@%h cnt %0d v %b want 042 041@041 1 1", i, InstAddress, IR, IRAddr, InstCount, IRValid);
      end
    end
    Stall = 1'b0;
    tick();
    checks++; if (IR !== 9'h042 || IRAddr !== 11'h042 || InstAddress !== 11'h043 || InstCount !== 16'd2) begin errors++; $display("FAIL stall_release: got ir %h@%h pc %h cnt %0d want 042@042 043 2", IR, IRAddr, InstAddress, InstCount); end
  endtask

  task automatic test_stall_branch();
    Stall = 1'b1; BranchTaken = 1'b1; BranchRel = 1'b0; BranchTarget = 11'h100;
    tick();
    Stall = 1'b0; BranchTaken = 1'b0;
    checks++; if (InstAddress !== 11'h100 || IRValid !== 1'b0 || InstCount !== 16'd3) begin errors++; $display("FAIL stall_branch: got pc %h v %b cnt %0d want 100 0 3", InstAddress, IRValid, InstCount); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    start_prog(11'h050);
    tick(); tick();
    #3;
    Reset = 1'b0;
    #1;
    checks++; if (InstAddress !== 11'h000 || IRValid !== 1'b0 || IR !== 9'h000 || InstCount !== 16'd0 || Ack !== 1'b0) begin
      errors++; $display("FAIL async_reset: got pc %h v %b ir %h cnt %0d ack %b want all zero", InstAddress, IRValid, IR, InstCount, Ack);
    end
    #2;
    Reset = 1'b1;
    tick(); tick();
    checks++; if (InstAddress !== 11'h000 || IRValid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got pc %h v %b want 000 0", InstAddress, IRValid); end
    start_prog(11'h050);
    tick();
    checks++; if (IR !== 9'h050 || IRAddr !== 11'h050 || IRValid !== 1'b1) begin errors++; $display("FAIL restart_after_reset: got %h@%h v%b want 050@050 v1", IR, IRAddr, IRValid); end
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; StartAddr = '0; Stall = 1'b0;
    BranchTaken = 1'b0; BranchRel = 1'b0; BranchTarget = '0;
    for (int i = 0; i < 2048; i++) rom[i] = 9'(i & 'hFF);
    rom[0] = 9'h001;
    rom[1] = 9'h049;
    rom[2] = 9'h1FF;
    test_reset();
    test_program();
    test_done_restart();
    test_abs_branch();
    test_rel_branch();
    test_rel_wrap();
    test_seq_wrap();
    test_branch_when_invalid();
    test_stall();
    test_stall_branch();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
